// File: rtl/alu_issue_stage.sv
// Registered issue/capture wrapper around alu_8bit: valid/ready request in, held result out.
// Optional operand chaining (alu_a from the previous result) is enabled by ALU_ISSUE_CHAIN_EN.
module alu_issue_stage #(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_a,
    input  logic [7:0]         in_b,
    input  logic [1:0]         in_ms,
    input  logic [1:0]         in_ss,
`ifdef ALU_ISSUE_CHAIN_EN
    input  logic               in_chain,
`endif
    output logic [7:0]         alu_a,
    output logic [7:0]         alu_b,
    output logic [1:0]         alu_ms,
    output logic [1:0]         alu_ss,
    input  logic [7:0]         alu_r,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_r,
    output logic               out_err,
    output logic [COUNT_W-1:0] op_count
);

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    state_t     state;
    logic       accept;
    logic       handoff;
    logic [7:0] a_sel;

    assign in_ready = !rst && ((state == IDLE) || (state == HOLD && out_ready));
    assign accept   = in_valid && in_ready;
    assign handoff  = (state == HOLD) && out_ready;

`ifdef ALU_ISSUE_CHAIN_EN
    logic [7:0] last_r;
    // A chained request accepted on the handoff edge must see the result leaving now.
    assign a_sel = in_chain ? (handoff ? out_r : last_r) : in_a;
`else
    assign a_sel = in_a;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_ms    <= '0;
            alu_ss    <= '0;
            out_valid <= 1'b0;
            out_r     <= '0;
            out_err   <= 1'b0;
            op_count  <= '0;
`ifdef ALU_ISSUE_CHAIN_EN
            last_r    <= '0;
`endif
        end else begin
            if (accept) begin
                alu_a  <= a_sel;
                alu_b  <= in_b;
                alu_ms <= in_ms;
                alu_ss <= in_ss;
            end
            if (handoff) begin
                out_valid <= 1'b0;
                op_count  <= op_count + COUNT_W'(1);
`ifdef ALU_ISSUE_CHAIN_EN
                last_r    <= out_r;
`endif
            end
            case (state)
                IDLE: if (accept) state <= ISSUE;
                ISSUE: begin
                    // Mode 2'b11 is undefined in the ALU: report it and drop its result.
                    out_valid <= 1'b1;
                    out_err   <= (alu_ms == 2'b11);
                    out_r     <= (alu_ms == 2'b11) ? 8'h00 : alu_r;
                    state     <= HOLD;
                end
                HOLD: if (out_ready) state <= accept ? ISSUE : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage with an XOR ALU stub; the driver queues
// expected results and a negedge monitor pops them on every output handshake.
module tb_alu_issue_stage;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [7:0]    in_a = '0;
    logic [7:0]    in_b = '0;
    logic [1:0]    in_ms = '0;
    logic [1:0]    in_ss = '0;
`ifdef ALU_ISSUE_CHAIN_EN
    logic          in_chain = 1'b0;
`endif
    logic          in_ready;
    logic [7:0]    alu_a, alu_b, alu_r, out_r;
    logic [1:0]    alu_ms, alu_ss;
    logic          out_valid, out_err;
    logic [CW-1:0] op_count;

    assign alu_r = alu_a ^ alu_b;

    alu_issue_stage #(.COUNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_ms(in_ms), .in_ss(in_ss),
`ifdef ALU_ISSUE_CHAIN_EN
        .in_chain(in_chain),
`endif
        .alu_a(alu_a), .alu_b(alu_b), .alu_ms(alu_ms), .alu_ss(alu_ss), .alu_r(alu_r),
        .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_err(out_err),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] r;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   passed = 0;
    int   cyc = 0;
    int   last_pop = -1;
    bit   sweep_on = 1'b0;

    logic [7:0] sw_a [12] = '{8'h01, 8'h10, 8'hFF, 8'hAA, 8'h80, 8'h3C,
                              8'h12, 8'hF0, 8'h0C, 8'h7F, 8'hC0, 8'h01};
    logic [7:0] sw_b [12] = '{8'h02, 8'h20, 8'h0F, 8'h55, 8'h01, 8'h3C,
                              8'h34, 8'h0F, 8'h0A, 8'h01, 8'h03, 8'h01};
    logic [7:0] sw_r [12] = '{8'h03, 8'h30, 8'hF0, 8'hFF, 8'h81, 8'h00,
                              8'h26, 8'hFF, 8'h06, 8'h7E, 8'hC3, 8'h00};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out_valid", out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                chk("out_r", out_r, e.r);
                chk("out_err", out_err, e.err);
                if (sweep_on && last_pop >= 0) chk("sweep_interval", cyc - last_pop, 2);
                last_pop = cyc;
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] ms,
                        input logic [1:0] ss, input logic [7:0] er, input logic ee);
        int n = 0;
        in_a = a; in_b = b; in_ms = ms; in_ss = ss; in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 50);
        if (!in_ready) chk("accept_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_q.push_back({er, ee});
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_pending", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        last_pop = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset held for two cycles
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_outs", {alu_a, alu_b, alu_ms, alu_ss, out_r, out_err}, 0);
        chk("rst_op_count", op_count, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // Single op
        out_ready = 1'b1;
        send(8'd10, 8'd5, 2'b00, 2'b00, 8'h0F, 1'b0);
        chk("single_alu_a", alu_a, 10);
        chk("single_alu_b", alu_b, 5);
        chk("single_early_valid", out_valid, 0);
        @(posedge clk); #1;
        chk("single_valid", out_valid, 1);
        chk("single_out_r", out_r, 8'h0F);
        @(posedge clk); #1;
        chk("single_op_count", op_count, 1);
        chk("single_valid_drop", out_valid, 0);

        // Backpressure, then release together with a new request
        out_ready = 1'b0;
        send(8'd7, 8'd2, 2'b00, 2'b00, 8'h05, 1'b0);
        @(posedge clk); #1;
        chk("bp_valid_first", out_valid, 1);
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_valid", out_valid, 1);
            chk("bp_out_r", out_r, 8'h05);
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        send(8'd3, 8'd1, 2'b00, 2'b00, 8'h02, 1'b0);
        chk("bp_same_edge_count", op_count, 2);
        chk("bp_same_edge_alu_a", alu_a, 3);
        drain();
        chk("bp_op_count", op_count, 3);

        // Illegal mode, then a legal op clears the flag
        send(8'hFF, 8'h01, 2'b11, 2'b00, 8'h00, 1'b1);
        @(posedge clk); #1;
        chk("illegal_err", out_err, 1);
        chk("illegal_out_r", out_r, 8'h00);
        send(8'h01, 8'h02, 2'b01, 2'b00, 8'h03, 1'b0);
        @(posedge clk); #1;
        chk("legal_err_clear", out_err, 0);
        drain();

        // Back-to-back sweep from a fresh counter
        do_reset();
        sweep_on = 1'b1;
        for (int i = 0; i < 12; i++)
            send(sw_a[i], sw_b[i], 2'(i / 4), 2'(i % 4), sw_r[i], 1'b0);
        drain();
        sweep_on = 1'b0;
        chk("sweep_op_count_wrap", op_count, 4);

        // Reset during ISSUE abandons the operation
        do_reset();
        send(8'd9, 8'd6, 2'b00, 2'b00, 8'h0F, 1'b0);
        void'(exp_q.pop_back());
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_outs", {alu_a, alu_b, out_r, out_err}, 0);
        chk("midrst_op_count", op_count, 0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("midrst_no_pulse", out_valid, 0);
        end

`ifdef ALU_ISSUE_CHAIN_EN
        send(8'd10, 8'd5, 2'b00, 2'b00, 8'h0F, 1'b0);
        in_chain = 1'b1;
        send(8'h77, 8'h0F, 2'b00, 2'b00, 8'h00, 1'b0);
        in_chain = 1'b0;
        chk("chain_bypass_alu_a", alu_a, 8'h0F);
        drain();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
